// File: rtl/proc_defs.sv
// Shared processor definitions: opcode values and fetch-unit state encodings,
// imported by fetch and decode.
package proc_defs;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HALT = 4'b0000,
    OP_ADDI = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_OUT  = 4'b1111
  } opcode_e;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: a redirect wins over increment, and the increment
// wraps naturally at 2^ADDR_W.
module pc_reg #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (jump_en) begin
      pc <= jump_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-entry output slot fed from a combinational ROM, with
// redirect, back-pressure stall and halt-on-opcode.
module fetch_unit
  import proc_defs::*;
#(
  parameter int                  ADDR_W  = 4,
  parameter int                  INST_W  = 16,
  parameter logic [OPCODE_W-1:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              is_halt_op;
  logic              load;
  logic              halt_hit;

  // rom_addr comes straight off the PC flop, so no input reaches it combinationally.
  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .inc       (load),
    .pc        (pc)
  );

  assign rom_addr   = pc;
  assign slot_free  = !instr_valid || instr_ready;
  assign is_halt_op = (rom_data[INST_W-1 -: OPCODE_W] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (jump_en) begin
      state_next = ST_FETCH;
    end else if (state == ST_FETCH && slot_free && is_halt_op) begin
      state_next = ST_HALTED;
    end
  end

  always_comb begin
    load     = 1'b0;
    halt_hit = 1'b0;
    halted   = (state == ST_HALTED);
    if (state == ST_FETCH && slot_free && !jump_en) begin
      load     = !is_halt_op;
      halt_hit = is_halt_op;
    end
  end

  // A handshake coinciding with a redirect or halt still empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (jump_en || halt_hit) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= rom_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, wrap, redirect, halt and
// asynchronous reset, against a behavioural ROM held in the bench.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [3:0]  jump_addr;
  logic        halted;

  logic [15:0] mem [16];
  int          tests = 0;
  int          fails = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted)
  );

  always #5 clk = ~clk;
  assign rom_data = mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word(input int i);
    return 16'hA000 | 16'(i * 16'h0101);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = word(i);
    rst = 1'b1; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    #2;
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", rom_addr, 0);

    // Stream from reset release.
    @(posedge clk); #1;
    rst = 1'b0; instr_ready = 1'b1;
    step();
    check("first_instr", instr, word(0));
    check("first_pc", instr_pc, 0);
    check("first_valid", instr_valid, 1);
    check("first_addr", rom_addr, 1);
    step();
    check("stream_pc1", instr_pc, 1);
    step();
    check("stream_pc2", instr_pc, 2);

    // Stall for three cycles at instr_pc=2.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instr, word(2));
      check("stall_pc", instr_pc, 2);
      check("stall_addr", rom_addr, 3);
      check("stall_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    step();
    check("unstall_instr", instr, word(3));
    check("unstall_pc", instr_pc, 3);

    // Wrap 14,15,0,1 without bubbles.
    jump_en = 1'b1; jump_addr = 4'd14;
    step();
    check("jmp14_valid", instr_valid, 0);
    check("jmp14_addr", rom_addr, 14);
    jump_en = 1'b0;
    step();
    check("wrap_pc14", instr_pc, 14);
    step();
    check("wrap_pc15", instr_pc, 15);
    step();
    check("wrap_pc0", instr_pc, 0);
    check("wrap_valid0", instr_valid, 1);
    check("wrap_instr0", instr, word(0));
    step();
    check("wrap_pc1", instr_pc, 1);

    // Redirect while stalled.
    instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 4'd8;
    step();
    check("jmp8_valid", instr_valid, 0);
    jump_en = 1'b0; instr_ready = 1'b1;
    step();
    check("jmp8_instr", instr, word(8));
    check("jmp8_pc", instr_pc, 8);
    check("jmp8_valid1", instr_valid, 1);

    // Halt on mem[5].
    mem[5] = 16'h0000;
    jump_en = 1'b1; jump_addr = 4'd4;
    step();
    jump_en = 1'b0;
    step();
    check("pre_halt_pc", instr_pc, 4);
    check("pre_halt_addr", rom_addr, 5);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_valid", instr_valid, 0);
      check("halt_flag", halted, 1);
      check("halt_addr", rom_addr, 5);
    end
    jump_en = 1'b1; jump_addr = 4'd0;
    step();
    check("resume_halted", halted, 0);
    check("resume_addr", rom_addr, 0);
    jump_en = 1'b0;
    step();
    check("resume_pc", instr_pc, 0);
    check("resume_valid", instr_valid, 1);
    check("resume_instr", instr, word(0));
    mem[5] = word(5);

    // Asynchronous reset in the middle of a stall at instr_pc=6.
    jump_en = 1'b1; jump_addr = 4'd6;
    step();
    jump_en = 1'b0;
    step();
    check("pre_rst_pc", instr_pc, 6);
    instr_ready = 1'b0;
    step();
    check("pre_rst_hold", instr_pc, 6);
    #1 rst = 1'b1;
    #1;
    check("arst_instr", instr, 0);
    check("arst_pc", instr_pc, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_addr", rom_addr, 0);
    step();
    check("arst_hold_valid", instr_valid, 0);
    rst = 1'b0; instr_ready = 1'b1;
    step();
    check("post_rst_pc", instr_pc, 0);
    check("post_rst_instr", instr, word(0));
    check("post_rst_valid", instr_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning program counter and ROM address width.
REQ-002 The block SHALL have parameter INST_W, default 16, meaning instruction width.
REQ-003 The block SHALL have parameter HALT_OP, default 4'b0000, meaning the opcode in instr[15:12] that stops fetching.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port rom_addr, output, ADDR_W bits, address to the combinational program ROM, equal to the current PC.
REQ-008 The block SHALL have port rom_data, input, INST_W bits, ROM instruction for rom_addr, valid in the same cycle.
REQ-009 The block SHALL have port instr, output, INST_W bits, registered instruction presented to decode.
REQ-010 The block SHALL have port instr_pc, output, ADDR_W bits, address from which instr was fetched.
REQ-011 The block SHALL have port instr_valid, output, 1 bit, meaning instr/instr_pc hold an undelivered instruction.
REQ-012 The block SHALL have port instr_ready, input, 1 bit, meaning decode accepts instr this cycle.
REQ-013 The block SHALL have port jump_en, input, 1 bit, one-cycle redirect request.
REQ-014 The block SHALL have port jump_addr, input, ADDR_W bits, redirect target.
REQ-015 The block SHALL have port halted, output, 1 bit, meaning the block is in HALTED.

Function
REQ-016 The block SHALL implement states FETCH and HALTED, with one output register slot (instr, instr_pc, instr_valid).
REQ-017 A handshake SHALL occur on a clock edge where instr_valid=1 and instr_ready=1.
REQ-018 In FETCH, the slot SHALL load when empty or handshaking: instr<=rom_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-019 Fetch latency SHALL be one cycle: the PC presented in cycle N appears on instr in cycle N+1.
REQ-020 With instr_valid=1 and instr_ready=0, instr, instr_pc, instr_valid and PC SHALL hold.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W, so 15 goes to 0 at the defaults.
REQ-022 jump_en=1 SHALL take priority over load, hold and halt: PC<=jump_addr, instr_valid<=0, state<=FETCH.
REQ-023 A handshake in the same cycle as jump_en SHALL still count as delivered; the slot is cleared and not reloaded that cycle.
REQ-024 If a load would capture rom_data[15:12]==HALT_OP, the block SHALL instead go to HALTED, keep instr_valid<=0, and hold PC at the halt address.
REQ-025 In HALTED, the block SHALL issue no loads, hold rom_addr stable, and hold halted=1; only jump_en or rst leaves HALTED.
REQ-026 rom_addr SHALL be driven directly from the PC register, with no combinational path from any input.

Reset
REQ-027 On rst=1, the block SHALL set PC=0, instr=0, instr_pc=0, instr_valid=0, halted=0 and state=FETCH, immediately and regardless of clk.
REQ-028 Reset asserted mid-stall or in HALTED SHALL discard the pending instruction; the first edge after release loads address 0.

Structure
REQ-029 Opcode constants (HALT, ADDI=0001, ADD=0010, SUB=0011, OUT=1111) and the state encodings SHALL reside in the shared proc_defs package/include used by decode.
REQ-030 The block SHALL be a single module; the PC register/incrementer MAY be a sub-module pc_reg, and no other sub-module SHALL be used.

Verification
REQ-031 Scenario: release rst with ready=1 and a ROM of non-halt words -> cycle 1 gives instr=mem[0], instr_pc=0, instr_valid=1; then one new instruction per cycle.
REQ-032 Scenario: ready=0 for 3 cycles while instr_pc=2 -> instr=mem[2] and rom_addr=3 are held; on ready=1, mem[3] follows next cycle.
REQ-033 Scenario: ready=1 fetching through 15 -> instr_pc sequence 14, 15, 0, 1, with no bubble.
REQ-034 Scenario: jump_en=1, jump_addr=8 while instr_valid=1 and ready=0 -> next cycle instr_valid=0; the cycle after, instr=mem[8], instr_pc=8.
REQ-035 Scenario: mem[5]=16'h0000 -> after instr_pc=4 is delivered, instr_valid=0, halted=1, rom_addr=5 held for 10 cycles; jump_en to 0 resumes fetching.
REQ-036 Scenario: assert rst mid-stall at instr_pc=6 -> outputs are 0 asynchronously; after release, instr_pc=0.
